// File: rtl/lif_setup_sequencer.sv
// Host-side initiator for the neuron setup/execute protocol: serialises one command into
// setup bytes, runs the neuron, counts spikes. Optional membrane capture: LIF_SEQ_MEMBRANE_EN.
module lif_setup_sequencer #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int RUN_BITS      = 8,
  parameter int SPIKE_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_target,
  input  logic [PAYLOAD_BITS-1:0] cmd_data,
  input  logic [2:0]              cmd_bytes,
  input  logic [RUN_BITS-1:0]     cmd_run,
  output logic [7:0]              data_out,
  output logic [2:0]              setup_control,
  output logic                    execute,
  input  logic                    spike_lif,
  input  logic                    spike_pwm,
  output logic                    done,
  output logic [RUN_BITS-1:0]     count_lif,
`ifdef LIF_SEQ_MEMBRANE_EN
  output logic [RUN_BITS-1:0]     count_pwm,
  input  logic [5:0]              membrane_in,
  output logic [5:0]              membrane_last
`else
  output logic [RUN_BITS-1:0]     count_pwm
`endif
);

  localparam int              MAX_BYTES  = PAYLOAD_BITS / 8;
  localparam int              IDX_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int              DRAIN_W    = $clog2(SPIKE_LATENCY + 1);
  localparam logic [2:0]      PARK_CODE  = 3'b100;
  localparam logic [2:0]      SHIFT_CODE = 3'b100;
  localparam logic [RUN_BITS-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                  state, next_state;
  logic [2:0]              target_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    run_nz;
  logic [RUN_BITS-1:0]     run_cnt;
  logic [IDX_W-1:0]        byte_idx;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic                    done_q;
  logic [2:0]              shadow_shift;
  logic [SPIKE_LATENCY-1:0] exec_pipe;
  logic [SPIKE_LATENCY:0]  pipe_ext;
  logic                    sample;
  logic [2:0]              eff_bytes;
  logic [7:0]              cur_byte;
  logic                    accept, load_last, finish;

  assign eff_bytes = (cmd_bytes > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : cmd_bytes;
  assign cur_byte  = data_q[{byte_idx, 3'b000} +: 8];
  assign pipe_ext  = {exec_pipe, execute};
  assign sample    = pipe_ext[SPIKE_LATENCY];
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    next_state    = state;
    cmd_ready     = 1'b0;
    execute       = 1'b0;
    // The receiver writes a register every non-execute cycle; rewriting shift with its own value is harmless.
    setup_control = PARK_CODE;
    data_out      = {5'b0, shadow_shift};
    accept        = 1'b0;
    load_last     = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (eff_bytes != 3'd0)     next_state = LOAD;
          else if (cmd_run != '0)    next_state = RUN;
          else                       finish     = 1'b1;
        end
      end
      LOAD: begin
        setup_control = target_q;
        data_out      = cur_byte;
        if (byte_idx == '0) begin
          load_last = 1'b1;
          if (run_nz) next_state = RUN;
          else begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      RUN: begin
        execute = 1'b1;
        if (run_cnt == RUN_BITS'(1)) next_state = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(1)) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the command latch is always reloaded on accept before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      target_q <= cmd_target;
      data_q   <= cmd_data;
      run_nz   <= (cmd_run != '0);
      run_cnt  <= cmd_run;
      byte_idx <= IDX_W'(eff_bytes - 3'd1);
    end else begin
      if (state == LOAD) byte_idx <= byte_idx - IDX_W'(1);
      if (state == RUN)  run_cnt  <= run_cnt - RUN_BITS'(1);
    end
    if (state == RUN)        drain_cnt <= DRAIN_W'(SPIKE_LATENCY);
    else if (state == DRAIN) drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q       <= 1'b0;
      shadow_shift <= 3'b000;
      exec_pipe    <= '0;
      count_lif    <= '0;
      count_pwm    <= '0;
    end else begin
      done_q    <= finish;
      exec_pipe <= pipe_ext[SPIKE_LATENCY-1:0];
      // The final byte lands in the receiver's low byte, so its low bits become the new shift value.
      if (load_last && target_q == SHIFT_CODE) shadow_shift <= cur_byte[2:0];
      if (accept && cmd_run != '0) begin
        count_lif <= '0;
        count_pwm <= '0;
      end else if (sample) begin
        if (spike_lif && count_lif != COUNT_MAX) count_lif <= count_lif + RUN_BITS'(1);
        if (spike_pwm && count_pwm != COUNT_MAX) count_pwm <= count_pwm + RUN_BITS'(1);
      end
    end
  end

`ifdef LIF_SEQ_MEMBRANE_EN
  // Runs are contiguous, so the last sampled cycle is the one whose pipe predecessor has already dropped.
  always_ff @(posedge clk) begin
    if (reset)                                     membrane_last <= 6'd0;
    else if (sample && !pipe_ext[SPIKE_LATENCY-1]) membrane_last <= membrane_in;
  end
`endif

endmodule

// File: tb/tb_lif_setup_sequencer.sv
// Scoreboard bench for lif_setup_sequencer: stimulus pushes expected command responses,
// a negedge monitor traces each command until done and compares against them.
module tb_lif_setup_sequencer;
  localparam int PAYLOAD_BITS  = 32;
  localparam int RUN_BITS      = 8;
  localparam int SPIKE_LATENCY = 1;
  localparam int TRACE_MAX     = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_target;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_bytes;
  logic [7:0]  cmd_run;
  logic [7:0]  data_out;
  logic [2:0]  setup_control;
  logic        execute;
  logic        spike_lif;
  logic        spike_pwm;
  logic        done;
  logic [7:0]  count_lif;
  logic [7:0]  count_pwm;
`ifdef LIF_SEQ_MEMBRANE_EN
  logic [5:0]  membrane_in = 6'd0;
  logic [5:0]  membrane_last;
`endif

  always #5 clk = ~clk;

  lif_setup_sequencer #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .RUN_BITS     (RUN_BITS),
    .SPIKE_LATENCY(SPIKE_LATENCY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_data     (cmd_data),
    .cmd_bytes    (cmd_bytes),
    .cmd_run      (cmd_run),
    .data_out     (data_out),
    .setup_control(setup_control),
    .execute      (execute),
    .spike_lif    (spike_lif),
    .spike_pwm    (spike_pwm),
    .done         (done),
    .count_lif    (count_lif),
`ifdef LIF_SEQ_MEMBRANE_EN
    .count_pwm    (count_pwm),
    .membrane_in  (membrane_in),
    .membrane_last(membrane_last)
`else
    .count_pwm    (count_pwm)
`endif
  );

  typedef struct {
    logic [2:0]  target;
    logic [31:0] data;
    int          k;
    int          run;
    int          latency;
    logic [2:0]  park_after;
    logic [7:0]  cnt_lif;
    logic [7:0]  cnt_pwm;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  model_shadow = 3'b000;
  logic [7:0]  model_lif    = 8'd0;
  logic [7:0]  model_pwm    = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Issues one command; mode 0 random spikes, 1 lif on even sampled cycles + pwm always, 2 pwm always.
  task automatic issue(input logic [2:0] tgt, input logic [31:0] data, input logic [2:0] nbytes,
                       input logic [7:0] run, input int mode, input bit junk);
    bit   sl[0:TRACE_MAX-1];
    bit   sp[0:TRACE_MAX-1];
    int   k, d, lo, hi, lif_sum, pwm_sum, waited;
    exp_t e;
    k  = (nbytes > 3'd4) ? 4 : int'(nbytes);
    d  = k + int'(run) + SPIKE_LATENCY + ((run != 0) ? 1 : 0);
    lo = k + 1 + SPIKE_LATENCY;
    hi = k + int'(run) + SPIKE_LATENCY;
    lif_sum = 0;
    pwm_sum = 0;
    for (int c = 0; c <= d; c++) begin
      bit in_win;
      in_win = (run != 0) && (c >= lo) && (c <= hi);
      sl[c] = 1'($urandom_range(0, 1));
      sp[c] = 1'($urandom_range(0, 1));
      if (mode == 1 && in_win) sl[c] = ((c - lo + 1) % 2 == 0);
      if (mode != 0) sp[c] = 1'b1;
      if (in_win) begin
        lif_sum += int'(sl[c]);
        pwm_sum += int'(sp[c]);
      end
    end
    e.target = tgt;
    e.data   = data;
    e.k      = k;
    e.run    = int'(run);
    e.latency = d;
    if (tgt == 3'b100 && k > 0) model_shadow = data[2:0];
    e.park_after = model_shadow;
    if (run != 0) begin
      model_lif = (lif_sum > 255) ? 8'd255 : 8'(lif_sum);
      model_pwm = (pwm_sum > 255) ? 8'd255 : 8'(pwm_sum);
    end
    e.cnt_lif = model_lif;
    e.cnt_pwm = model_pwm;
    sb_q.push_back(e);

    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_data   = data;
    cmd_bytes  = nbytes;
    cmd_run    = run;
    waited     = 0;
    while (!cmd_ready && waited < 500) begin
      spike_lif = 1'($urandom_range(0, 1));
      spike_pwm = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", waited, 0);
      finish_run();
    end
    spike_lif = sl[0];
    spike_pwm = sp[0];
    @(posedge clk); #1;
    for (int c = 1; c <= d; c++) begin
      spike_lif = sl[c];
      spike_pwm = sp[c];
      if (junk && c < d) begin
        cmd_valid  = 1'b1;
        cmd_target = ~tgt;
        cmd_data   = ~data;
        cmd_bytes  = 3'd2;
        cmd_run    = 8'd1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      spike_lif = 1'($urandom_range(0, 1));
      spike_pwm = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // Monitor: trace outputs per cycle from accept to done, then compare with the queued expectation.
  bit         mon_active = 1'b0;
  int         mon_age    = 0;
  logic [7:0] tr_data [0:TRACE_MAX-1];
  logic [2:0] tr_ctl  [0:TRACE_MAX-1];
  bit         tr_exec [0:TRACE_MAX-1];
  bit         tr_ready[0:TRACE_MAX-1];

  task automatic finalize();
    exp_t       e;
    logic [7:0] exp_byte;
    logic [10:0] park_act;
    int         n_exec, first_exec, last_exec;
    bit         busy_ready;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("latency", mon_age, e.latency);
    for (int c = 1; c <= e.k && c <= mon_age; c++) begin
      exp_byte = 8'(e.data >> (8 * (e.k - c)));
      check("load_byte", {tr_ctl[c], tr_data[c]}, {e.target, exp_byte});
    end
    park_act = {3'b100, 5'b0, e.park_after};
    n_exec = 0; first_exec = 0; last_exec = 0; busy_ready = 1'b0;
    for (int c = 1; c <= mon_age; c++) begin
      if (c > e.k && park_act == {3'b100, 5'b0, e.park_after} &&
          {tr_ctl[c], tr_data[c]} != {3'b100, 5'b0, e.park_after})
        park_act = {tr_ctl[c], tr_data[c]};
      if (tr_exec[c]) begin
        n_exec++;
        if (first_exec == 0) first_exec = c;
        last_exec = c;
      end
      if (c < mon_age && tr_ready[c]) busy_ready = 1'b1;
    end
    check("park_outputs", park_act, {3'b100, 5'b0, e.park_after});
    check("exec_cycles", n_exec, e.run);
    if (e.run > 0) check("exec_window", {32'(first_exec), 32'(last_exec)}, {32'(e.k + 1), 32'(e.k + e.run)});
    check("ready_busy", busy_ready, 1'b0);
    check("count_lif", count_lif, e.cnt_lif);
    check("count_pwm", count_pwm, e.cnt_pwm);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (mon_active) begin
          mon_age++;
          if (mon_age < TRACE_MAX) begin
            tr_data[mon_age]  = data_out;
            tr_ctl[mon_age]   = setup_control;
            tr_exec[mon_age]  = execute;
            tr_ready[mon_age] = cmd_ready;
          end
          if (done) begin
            finalize();
            mon_active = 1'b0;
          end else if (mon_age >= TRACE_MAX - 50) begin
            check("done_timeout", mon_age, 0);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            mon_active = 1'b0;
          end
        end else if (done) begin
          check("spurious_done", done, 1'b0);
        end
        if (!mon_active && cmd_valid && cmd_ready) begin
          mon_active = 1'b1;
          mon_age    = 0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0] targets [0:5];
    targets = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
    reset = 1'b1; cmd_valid = 1'b0; cmd_target = 3'b0; cmd_data = 32'h0;
    cmd_bytes = 3'd0; cmd_run = 8'd0; spike_lif = 1'b0; spike_pwm = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_execute", execute, 1'b0);
    check("reset_setup_control", setup_control, 3'b100);
    check("reset_data_out", data_out, 8'h00);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_counts", {count_lif, count_pwm}, 16'h0);
    check("reset_done", done, 1'b0);

    issue(3'b001, 32'hA1B2C3D4, 3'd4, 8'd0, 0, 1'b0);
    issue(3'b100, 32'h00000003, 3'd1, 8'd0, 0, 1'b0);
    issue(3'b010, 32'h00000005, 3'd1, 8'd0, 0, 1'b0);
    idle(1);
    check("park_after_threshold", {setup_control, data_out}, {3'b100, 8'h03});
    issue(3'b000, 32'h0, 3'd0, 8'd10, 1, 1'b0);
    issue(3'b000, 32'h0, 3'd0, 8'd255, 2, 1'b0);

    // Second long run, cut short by reset while execute is high.
    cmd_valid = 1'b1; cmd_target = 3'b000; cmd_bytes = 3'd0; cmd_run = 8'd50;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    idle(20);
    check("pre_reset_execute", execute, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_shadow = 3'b000; model_lif = 8'd0; model_pwm = 8'd0;
    check("midrun_reset_execute", execute, 1'b0);
    check("midrun_reset_counts", {count_lif, count_pwm}, 16'h0);
    check("midrun_reset_park", {setup_control, data_out}, {3'b100, 8'h00});
    for (int i = 0; i < 5; i++) begin
      check("midrun_reset_no_done", done, 1'b0);
      idle(1);
    end

    issue(3'b011, 32'h12345678, 3'd4, 8'd3, 0, 1'b1);
    issue(3'b100, 32'hFFFFFF06, 3'd7, 8'd2, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [7:0] run;
      run = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      issue(targets[$urandom_range(0, 5)], $urandom, 3'($urandom_range(0, 7)), run, 0,
            $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("scoreboard_empty", sb_q.size(), 0);
    finish_run();
  end

endmodule
